// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_pkg
//  Description : Shared types for the systolic MAC array. Holds the FSM state
//                enum, default element widths and the saturating-add helper
//                used when MAC_SAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  localparam int TPU_BITS_AB = 8;
  localparam int TPU_BITS_C  = 16;
  localparam int TPU_DIM     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FLUSH   = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  typedef logic signed [TPU_BITS_AB-1:0] ab_t;
  typedef logic signed [TPU_BITS_C-1:0]  c_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the sum to a signed range of
  // 'bits' bits; ovf flags that a clamp happened. Valid for bits up to 62.
  function automatic sat_res_t sat_add(input logic signed [63:0] acc,
                                       input logic signed [63:0] addend,
                                       input int unsigned        bits);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           res;
    sum     = acc + addend;
    hi      = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (bits - 1));
    res.ovf = 1'b0;
    res.val = sum;
    if (sum > hi) begin
      res.ovf = 1'b1;
      res.val = hi;
    end else if (sum < lo) begin
      res.ovf = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_pe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pe
//  Description : One output-stationary processing element. Registers A and B
//                for its right/lower neighbours and keeps a signed accumulator
//                with clear / load / accumulate controls (in that priority).
//                Optional macro MAC_SAT_EN: clamp on overflow and report it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_pe
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [BITS_C-1:0]  load_val_i,
  input  logic               acc_en_i,
  input  logic [BITS_AB-1:0] a_i,
  input  logic [BITS_AB-1:0] b_i,
  output logic [BITS_AB-1:0] a_o,
  output logic [BITS_AB-1:0] b_o,
  output logic [BITS_C-1:0]  acc_o,
  output logic               sat_o
);

  logic [BITS_AB-1:0]        a_q;
  logic [BITS_AB-1:0]        b_q;
  logic [BITS_C-1:0]         acc_q;
  logic [BITS_C-1:0]         acc_d;
  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]  prod_ext;
`ifdef MAC_SAT_EN
  sat_res_t                  sum_res;
`endif

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = BITS_C'(prod);

  // Next accumulator value: clear beats load beats accumulate.
  always_comb begin
    acc_d = acc_q;
    sat_o = 1'b0;
`ifdef MAC_SAT_EN
    sum_res = '0;
`endif
    if (clr_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = load_val_i;
    end else if (acc_en_i) begin
`ifdef MAC_SAT_EN
      sum_res = sat_add(64'($signed(acc_q)), 64'(prod_ext), BITS_C);
      acc_d   = sum_res.val[BITS_C-1:0];
      sat_o   = sum_res.ovf;
`else
      acc_d   = acc_q + prod_ext;
`endif
    end
  end

  // Operand pass-through registers and the accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/systolic_mac_array.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_mac_array
//  Description : DIM x DIM output-stationary systolic array computing
//                C (+)= A*B from streamed A-column / B-row vectors. Skews the
//                inputs, flushes 2*DIM-1 cycles, then drains C a row per cycle.
//                Optional macro MAC_SAT_EN: saturating accumulate + sticky sat.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_mac_array
  import tpu_pkg::*;
#(
  parameter int BITS_AB = TPU_BITS_AB,
  parameter int BITS_C  = TPU_BITS_C,
  parameter int DIM     = TPU_DIM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     acc_clr,
  input  logic                     c_wr,
  input  logic [$clog2(DIM)-1:0]   c_addr,
  input  logic [DIM*BITS_C-1:0]    c_row,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [DIM*BITS_AB-1:0]   a_vec,
  input  logic [DIM*BITS_AB-1:0]   b_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM*BITS_C-1:0]    out_row,
  output logic                     out_last,
  output logic                     busy,
  output logic                     sat
);

  localparam int AW = $clog2(DIM);
  localparam int FW = $clog2(2 * DIM);

  state_e            state_q, state_d;
  logic [AW-1:0]     row_q, row_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              sat_q, sat_d;

  logic              in_hs;
  logic              clr_all;
  logic              load_en;
  logic              acc_en;
  logic              sat_any;
  logic [DIM*DIM-1:0] sat_vec;

  // Operand buses: a_bus[i][j] / b_bus[i][j] are the inputs of PE(i,j).
  logic [BITS_AB-1:0] a_bus [DIM][DIM+1];
  logic [BITS_AB-1:0] b_bus [DIM+1][DIM];
  logic [BITS_C-1:0]  acc_w [DIM][DIM];

  assign in_ready  = (state_q == COMPUTE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && (row_q == AW'(DIM - 1));
  assign in_hs     = in_valid && in_ready;
  assign clr_all   = (state_q == IDLE) && start && acc_clr;
  assign load_en   = (state_q == IDLE) && c_wr && !clr_all;
  assign acc_en    = (state_q == COMPUTE) || (state_q == FLUSH);
  assign sat_any   = |sat_vec;
  // The wrap build's PEs never report a clamp, so sat stays 0 there.
  assign sat       = sat_q;

  // Next-state logic: sequencing, flush timer, drain row pointer, sticky sat.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    flush_d = flush_q;
    sat_d   = sat_q | sat_any;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          sat_d   = 1'b0;
        end
      end
      COMPUTE: begin
        if (in_hs && in_last) begin
          state_d = FLUSH;
          flush_d = '0;
        end
      end
      FLUSH: begin
        if (flush_q == FW'(2 * DIM - 2)) begin
          state_d = DRAIN;
          row_d   = '0;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (row_q == AW'(DIM - 1)) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      flush_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      flush_q <= flush_d;
      sat_q   <= sat_d;
    end
  end

  // Input skew: row/column i is delayed i cycles so that A[i][k] and B[k][j]
  // meet in PE(i,j) on the same edge. Cycles without a handshake feed zeros.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_skew
    logic [BITS_AB-1:0] a_feed;
    logic [BITS_AB-1:0] b_feed;
    assign a_feed = in_hs ? a_vec[gi*BITS_AB +: BITS_AB] : '0;
    assign b_feed = in_hs ? b_vec[gi*BITS_AB +: BITS_AB] : '0;
    if (gi == 0) begin : g_direct
      assign a_bus[0][0] = a_feed;
      assign b_bus[0][0] = b_feed;
    end else begin : g_delay
      logic [BITS_AB-1:0] a_sr_q [gi];
      logic [BITS_AB-1:0] b_sr_q [gi];
      // Shift chain of gi stages toward the array edge.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < gi; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else begin
          a_sr_q[0] <= a_feed;
          b_sr_q[0] <= b_feed;
          for (int s = 1; s < gi; s++) begin
            a_sr_q[s] <= a_sr_q[s-1];
            b_sr_q[s] <= b_sr_q[s-1];
          end
        end
      end
      assign a_bus[gi][0] = a_sr_q[gi-1];
      assign b_bus[0][gi] = b_sr_q[gi-1];
    end
  end

  // PE grid: A moves right along a row, B moves down a column.
  for (genvar gr = 0; gr < DIM; gr++) begin : g_row
    for (genvar gc = 0; gc < DIM; gc++) begin : g_col
      mac_pe #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C)
      ) u_pe (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_all),
        .load_i     (load_en && (c_addr == AW'(gr))),
        .load_val_i (c_row[gc*BITS_C +: BITS_C]),
        .acc_en_i   (acc_en),
        .a_i        (a_bus[gr][gc]),
        .b_i        (b_bus[gr][gc]),
        .a_o        (a_bus[gr][gc+1]),
        .b_o        (b_bus[gr+1][gc]),
        .acc_o      (acc_w[gr][gc]),
        .sat_o      (sat_vec[gr*DIM+gc])
      );
    end
  end

  // Drain mux: present accumulator row row_q while draining, zero otherwise.
  always_comb begin
    out_row = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < DIM; j++) begin
        out_row[j*BITS_C +: BITS_C] = acc_w[row_q][j];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/systolic_mac_array.md
# systolic_mac_array

Parametrised DIM×DIM output-stationary systolic array of signed MAC processing elements. It computes C = A·B (+ preloaded C) for streamed A-column/B-row vector pairs of arbitrary inner length K. It skews inputs internally, flushes the pipeline, then drains C one row per cycle over a ready/valid port. This is the next generation of the single-PE MAC tile, and the matrix engine of the TPU datapath.

## Interface
- BITS_AB, 8, signed operand width of A and B elements
- BITS_C, 16, signed accumulator and C element width (≥ 2·BITS_AB)
- DIM, 4, array dimension (≥ 2)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin operation; honoured only in IDLE
- acc_clr  in  1  sampled with start; 1 = zero all accumulators, 0 = keep current C
- c_wr  in  1  IDLE only: write c_row into accumulator row c_addr
- c_addr  in  clog2(DIM)  preload row index
- c_row  in  DIM·BITS_C  preload row, element j at bits [j·BITS_C +: BITS_C]
- in_valid / in_ready  in / out  1  vector handshake; in_ready=1 only in COMPUTE
- in_last  in  1  marks the final vector (k = K−1); meaningful only on handshake
- a_vec  in  DIM·BITS_AB  column k of A, element i feeds row i
- b_vec  in  DIM·BITS_AB  row k of B, element j feeds column j
- out_valid / out_ready  out / in  1  drain handshake
- out_row  out  DIM·BITS_C  current C row, same packing as c_row
- out_last  out  1  high with the final drained row (DIM−1)
- busy  out  1  state ≠ IDLE
- sat  out  1  sticky saturation flag, cleared on start

## Operation
- States: IDLE → COMPUTE → FLUSH → DRAIN → IDLE.
- IDLE: start → COMPUTE; if acc_clr, all PEs zeroed on the same edge. c_wr writes row c_addr. Priority when start&acc_clr&c_wr: clear wins. When start&!acc_clr&c_wr: the write lands and is kept.
- COMPUTE: on each handshake, a_vec[i] enters an i-stage skew register and b_vec[j] enters a j-stage skew register. Cycles without a handshake inject zeros, so bubbles are harmless. The array advances every cycle: A shifts right, B shifts down. Each PE does acc += a·b.
- Handshake with in_last → FLUSH. FLUSH runs exactly 2·DIM−1 cycles of zero injection, then → DRAIN.
- DRAIN: row counter r=0..DIM−1. out_row = C[r] and out_valid=1. r advances on out_valid&out_ready. out_last when r=DIM−1. The handshake at DIM−1 → IDLE. Accumulators retain values after drain.
- Arithmetic: the BITS_AB×BITS_AB signed product is sign-extended to BITS_C, then added. Default is two's-complement wrap mod 2^BITS_C.
- Ignored inputs: start, c_wr and acc_clr outside IDLE; in_last without handshake.

## Timing
- Reset (rst_n=0 at edge): state IDLE, all accumulators and skew/shift registers 0. Outputs: in_ready=0, out_valid=0, out_last=0, out_row=0, busy=0, sat=0. Applies mid-operation: any state → IDLE, C lost.
- start accepted at edge t → in_ready=1 and busy=1 from cycle t+1.
- in_last handshake at edge t → in_ready=0 from t+1. First out_valid at cycle t+2·DIM.
- out_row and out_last are registered-state driven and held stable while out_valid&!out_ready.
- Minimum op latency, K vectors, no stalls: K + 2·DIM + DIM cycles from start to IDLE.

## Configuration
- MAC_SAT_EN defined: each accumulate clamps to [−2^(BITS_C−1), 2^(BITS_C−1)−1]. Any clamp sets sat, which holds until the next accepted start or reset.
- MAC_SAT_EN undefined: wrap arithmetic, and sat is tied 0.

## Structure
- Package tpu_pkg: state enum (IDLE, COMPUTE, FLUSH, DRAIN), signed element typedefs parametrised via localparams, and a saturating-add function.
- Sub-module mac_pe: one PE with A/B pass-through registers, accumulator with clr/load/accumulate controls, and a saturation-event output. It is instantiated DIM² times via generate. The FSM, skew registers, counters and drain mux live in the top.

## Test plan
- DIM=2, acc_clr=1. Vectors (a,b) = ((1,3),(5,6)) then ((2,4),(7,8)) with in_last → rows (19,22), (43,50), out_last on row 1, busy low after.
- Preload c_addr=0 row (100,−100), c_addr=1 row (0,0), acc_clr=0, same vectors → (119,−78), (43,50).
- in_valid low for 3 cycles between the two vectors, and out_ready low 3 cycles during row 0 → same results. out_row stable while stalled.
- BITS_AB=8, BITS_C=16, all elements 127, K=3 → 48387 per element. Without MAC_SAT_EN: −17149, sat=0. With MAC_SAT_EN: 32767, sat=1.
- rst_n low for 1 cycle during FLUSH → IDLE, outputs 0. Fresh start with acc_clr=1 gives correct results.
- start, c_wr and in_last pulsed in wrong states (COMPUTE, DRAIN, IDLE respectively) → no state or accumulator change.
